// File: rtl/rvv_backend_rob_wr_arb.sv
// ============================================================================
// Module      : rvv_backend_rob_wr_arb
// Description : Round-robin write-port arbiter between the PU result channels
//               (ALU, PMTRDT, MUL, DIV, LSU) and the ROB result-write ports.
//               Each requester owns a 1-entry holding slot.  Every cycle up to
//               K held results are granted, where K is the number of ROB ports
//               that are ready.  Requesters are scanned from the round-robin
//               pointer upward, wrapping at NUM_REQ.  The n-th granted
//               requester is placed on the n-th ready port, counting ports
//               from index 0.
// Ports       : clk, rst_n              clock, asynchronous active-low reset
//               req_valid/req_data      PU result channels (NUM_REQ)
//               req_ready               holding slot can accept this cycle
//               port_valid/port_data    ROB write ports (NUM_PORT)
//               port_ready              ROB port accepts
//               flush                   discard every held result
//               rr_ptr_o                current highest-priority requester
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvv_backend_rob_wr_arb_pkg;
    // PU-to-ROB result payload.  The arbiter never looks inside it; only the
    // optional checks use rob_entry.
    typedef struct packed {
        logic [3:0]  rob_entry;
        logic [31:0] w_data;
    } PU2ROB_t;
endpackage

module rvv_backend_rob_wr_arb
    import rvv_backend_rob_wr_arb_pkg::*;
#(
    parameter type T        = PU2ROB_t,
    parameter int  NUM_REQ  = 9,
    parameter int  NUM_PORT = 8,
    parameter int  REQ_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  T                    req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_ready,
    output logic [NUM_PORT-1:0] port_valid,
    output T                    port_data [NUM_PORT],
    input  logic [NUM_PORT-1:0] port_ready,
    input  logic                flush,
    output logic [REQ_W-1:0]    rr_ptr_o
);

    localparam int c_PORT_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0] hold_valid_q;
    logic [NUM_REQ-1:0] hold_valid_d;
    T                   hold_data_q [NUM_REQ];
    T                   hold_data_d [NUM_REQ];
    logic [REQ_W-1:0]   rr_ptr_q;
    logic [REQ_W-1:0]   rr_ptr_d;

    // ------------------------------------------------------------------------
    // Grant results
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_granted;
    logic               w_any_grant;
    logic [REQ_W-1:0]   w_last_idx;
    // Requester index of the n-th grant, in scan order.
    logic [REQ_W-1:0]   w_sel_idx [NUM_PORT];

    assign rr_ptr_o = rr_ptr_q;

    // ------------------------------------------------------------------------
    // Grant selection and port mapping.
    // A grant is only issued against a ready port, so whatever is shown on a
    // port transfers in the same cycle and never has to be held over a stall.
    // ------------------------------------------------------------------------
    always_comb begin : p_grant
        int               k_ports;
        int               n_sel;
        int               n_map;
        int               scan;
        logic [REQ_W-1:0] idx;

        w_granted   = '0;
        w_any_grant = 1'b0;
        w_last_idx  = rr_ptr_q;
        port_valid  = '0;
        k_ports     = 0;
        n_sel       = 0;
        n_map       = 0;
        scan        = 0;
        idx         = '0;
        for (int n = 0; n < NUM_PORT; n++) begin
            w_sel_idx[c_PORT_W'(n)] = '0;
            port_data[c_PORT_W'(n)] = '0;
        end

        for (int j = 0; j < NUM_PORT; j++) begin
            if (port_ready[c_PORT_W'(j)]) begin
                k_ports = k_ports + 1;
            end
        end

        if (!flush) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                // The wrap is modulo NUM_REQ, not modulo 2**REQ_W.
                scan = int'(rr_ptr_q) + off;
                if (scan >= NUM_REQ) begin
                    scan = scan - NUM_REQ;
                end
                idx = REQ_W'(scan);
                if (hold_valid_q[idx] && (n_sel < k_ports)) begin
                    w_granted[idx]              = 1'b1;
                    w_sel_idx[c_PORT_W'(n_sel)] = idx;
                    w_last_idx                  = idx;
                    w_any_grant                 = 1'b1;
                    n_sel                       = n_sel + 1;
                end
            end
        end

        for (int j = 0; j < NUM_PORT; j++) begin
            if (port_ready[c_PORT_W'(j)] && (n_map < n_sel)) begin
                port_valid[c_PORT_W'(j)] = 1'b1;
                port_data[c_PORT_W'(j)]  = hold_data_q[w_sel_idx[c_PORT_W'(n_map)]];
                n_map                    = n_map + 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Slot next state, ready and pointer update.
    // A slot being granted this cycle can be refilled in the same cycle, which
    // gives every requester one result per cycle of throughput.
    // ------------------------------------------------------------------------
    always_comb begin : p_next
        logic [REQ_W-1:0] ri;

        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        req_ready    = '0;
        ri           = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            ri            = REQ_W'(i);
            req_ready[ri] = ~flush & (~hold_valid_q[ri] | w_granted[ri]);
            if (flush) begin
                hold_valid_d[ri] = 1'b0;
            end else if (req_valid[ri] && req_ready[ri]) begin
                hold_valid_d[ri] = 1'b1;
                hold_data_d[ri]  = req_data[ri];
            end else if (w_granted[ri]) begin
                hold_valid_d[ri] = 1'b0;
            end
        end

        // Priority moves to the requester just after the last one served.
        rr_ptr_d = rr_ptr_q;
        if (w_any_grant) begin
            if (w_last_idx == REQ_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = w_last_idx + REQ_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Payload storage is qualified by hold_valid_q and needs no reset.
    always_ff @(posedge clk) begin : p_data
        hold_data_q <= hold_data_d;
    end

`ifdef ASSERT_ON
    // ------------------------------------------------------------------------
    // Protocol and fairness checks
    // ------------------------------------------------------------------------
    localparam int c_MAX_WAIT = (NUM_REQ + NUM_PORT - 1) / NUM_PORT + 1;

    logic [7:0] wait_cnt_q [NUM_REQ];
    logic [7:0] wait_cnt_d [NUM_REQ];
    logic       w_dup_entry;

    // Cycles a held requester has gone ungranted while every port was ready.
    always_comb begin : p_wait_next
        logic [REQ_W-1:0] ri;
        ri = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ri = REQ_W'(i);
            if (hold_valid_q[ri] && !w_granted[ri] && (&port_ready) && !flush) begin
                wait_cnt_d[ri] = wait_cnt_q[ri] + 8'd1;
            end else begin
                wait_cnt_d[ri] = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_wait
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[REQ_W'(i)] <= 8'd0;
            end
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin : p_dup
        w_dup_entry = 1'b0;
        for (int a = 0; a < NUM_PORT; a++) begin
            for (int b = a + 1; b < NUM_PORT; b++) begin
                if (port_valid[c_PORT_W'(a)] && port_valid[c_PORT_W'(b)] &&
                    (port_data[c_PORT_W'(a)].rob_entry == port_data[c_PORT_W'(b)].rob_entry)) begin
                    w_dup_entry = 1'b1;
                end
            end
        end
    end

    a_valid_needs_ready : assert property (@(posedge clk) disable iff (!rst_n)
        (port_valid & ~port_ready) == '0);

    // Each grant occupies exactly one port, so a double grant would show up
    // as a mismatch between granted requesters and valid ports.
    a_single_grant : assert property (@(posedge clk) disable iff (!rst_n)
        $countones(w_granted) == $countones(port_valid));

    a_unique_rob_entry : assert property (@(posedge clk) disable iff (!rst_n)
        !w_dup_entry);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wait_chk
        a_no_starve : assert property (@(posedge clk) disable iff (!rst_n)
            wait_cnt_q[gi] < 8'(c_MAX_WAIT));
    end
`endif

endmodule

`default_nettype wire
